// File: rtl/ssd1306_spi_rx_pkg.sv
// Shared SSD1306 opcodes and encodings for the SPI receive-side command decoder.
package ssd1306_spi_rx_pkg;

  localparam logic [7:0] SET_MEM_MODE    = 8'h20;
  localparam logic [7:0] SET_COL_ADDR    = 8'h21;
  localparam logic [7:0] SET_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] SET_CONTRAST    = 8'h81;
  localparam logic [7:0] SET_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] SET_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] DISP_OFF        = 8'hAE;
  localparam logic [7:0] DISP_ON         = 8'hAF;
  localparam logic [7:0] PAGE_BASE       = 8'hB0;
  localparam logic [7:0] SET_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] SET_CLK_DIV     = 8'hD5;
  localparam logic [7:0] SET_PRECHARGE   = 8'hD9;
  localparam logic [7:0] SET_COM_PINS    = 8'hDA;
  localparam logic [7:0] SET_VCOM_DESEL  = 8'hDB;

  typedef enum logic [1:0] {
    StIdle,
    StArg1,
    StArg2
  } dec_state_e;

  typedef enum logic {
    ModeHoriz,
    ModePage
  } addr_mode_e;

  // Opcodes followed by exactly one argument byte.
  function automatic logic takes_one_arg(input logic [7:0] op);
    return (op == SET_MEM_MODE)    || (op == SET_CONTRAST)    || (op == SET_CHARGE_PUMP) ||
           (op == SET_MUX_RATIO)   || (op == SET_DISP_OFFSET) || (op == SET_CLK_DIV)     ||
           (op == SET_PRECHARGE)   || (op == SET_COM_PINS)    || (op == SET_VCOM_DESEL);
  endfunction

endpackage

// File: rtl/ssd1306_spi_rx_byte.sv
// SPI mode-0 byte receiver: input synchronisers, SCK rising-edge detect, shift and bit count.
module spi_rx_byte #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic       ss_i,
  input  logic       dc_i,
  output logic [7:0] byte_o,
  output logic       dc_o,
  output logic       valid_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ss_sync_q, dc_sync_q;
  logic                   sck_s, mosi_s, ss_s, dc_s, rise;
  logic                   sck_prev_q;
  logic [2:0]             cnt_q;
  logic [6:0]             shift_q;
  logic [7:0]             byte_q;
  logic                   dc_q, valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      dc_sync_q   <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc_i};
    end
  end

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev_q;

  // A deselected link drops the partial byte simply by restarting the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_prev_q <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      dc_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sck_prev_q <= sck_s;
      valid_q    <= 1'b0;
      if (ss_s) begin
        cnt_q <= '0;
      end else if (rise) begin
        shift_q <= {shift_q[5:0], mosi_s};
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          byte_q  <= {shift_q, mosi_s};
          dc_q    <= dc_s;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign byte_o  = byte_q;
  assign dc_o    = dc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ssd1306_spi_rx.sv
// SSD1306 SPI responder: decodes command bytes and turns data bytes into frame-buffer writes.
module ssd1306_spi_rx
  import ssd1306_spi_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned COLS          = 128,
  parameter int unsigned PAGES         = 8,
  parameter int unsigned FB_ADDR_WIDTH = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     spi_sck_i,
  input  logic                     spi_mosi_i,
  input  logic                     spi_ss_i,
  input  logic                     spi_dc_i,
  output logic [FB_ADDR_WIDTH-1:0] fb_addr_o,
  output logic [7:0]               fb_dat_o,
  output logic                     fb_wr_o,
  output logic [7:0]               cmd_o,
  output logic                     cmd_stb_o,
  output logic                     disp_on_o,
  output logic [7:0]               contrast_o,
  output logic                     frame_o
);

  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned PAGE_W = $clog2(PAGES);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLS - 1);
  localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(PAGES - 1);

  logic [7:0] rx_byte;
  logic       rx_dc, rx_valid;

  spi_rx_byte #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_byte (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sck_i  (spi_sck_i),
    .mosi_i (spi_mosi_i),
    .ss_i   (spi_ss_i),
    .dc_i   (spi_dc_i),
    .byte_o (rx_byte),
    .dc_o   (rx_dc),
    .valid_o(rx_valid)
  );

  dec_state_e               state_q, state_d;
  addr_mode_e               mode_q, mode_d;
  logic [COL_W-1:0]         col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PAGE_W-1:0]        page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [COL_W-1:0]         col_inc;
  logic [PAGE_W-1:0]        page_inc;
  logic [7:0]               cmd_q, cmd_d, contrast_q, contrast_d, dat_q, dat_d;
  logic                     disp_on_q, disp_on_d;
  logic [FB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                     wr_q, wr_d, stb_q, stb_d, frame_q, frame_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      mode_q       <= ModePage;
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= COL_MAX;
      page_start_q <= '0;
      page_end_q   <= PAGE_MAX;
      cmd_q        <= 8'h00;
      contrast_q   <= 8'h7F;
      disp_on_q    <= 1'b0;
      dat_q        <= '0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      stb_q        <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      cmd_q        <= cmd_d;
      contrast_q   <= contrast_d;
      disp_on_q    <= disp_on_d;
      dat_q        <= dat_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      stb_q        <= stb_d;
      frame_q      <= frame_d;
    end
  end

  // Pointer steps wrap at the display edge independently of the window.
  assign col_inc  = (col_q == COL_MAX) ? '0 : col_q + COL_W'(1);
  assign page_inc = (page_q == PAGE_MAX) ? '0 : page_q + PAGE_W'(1);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    col_d        = col_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    cmd_d        = cmd_q;
    contrast_d   = contrast_q;
    disp_on_d    = disp_on_q;
    dat_d        = dat_q;
    addr_d       = addr_q;
    wr_d         = 1'b0;
    stb_d        = 1'b0;
    frame_d      = 1'b0;

    if (rx_valid) begin
      if (rx_dc) begin
        // Data always wins: any half-received command is abandoned.
        state_d = StIdle;
        addr_d  = FB_ADDR_WIDTH'(page_q) * FB_ADDR_WIDTH'(COLS) + FB_ADDR_WIDTH'(col_q);
        dat_d   = rx_byte;
        wr_d    = 1'b1;
        if (col_q == col_end_q) begin
          col_d = col_start_q;
          if (mode_q == ModeHoriz) begin
            if (page_q == page_end_q) begin
              page_d  = page_start_q;
              frame_d = 1'b1;
            end else begin
              page_d = page_inc;
            end
          end
        end else begin
          col_d = col_inc;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            stb_d = 1'b1;
            cmd_d = rx_byte;
            if (rx_byte == SET_COL_ADDR || rx_byte == SET_PAGE_ADDR || takes_one_arg(rx_byte)) begin
              state_d = StArg1;
            end else if (rx_byte == DISP_OFF) begin
              disp_on_d = 1'b0;
            end else if (rx_byte == DISP_ON) begin
              disp_on_d = 1'b1;
            end else if (rx_byte[7:3] == PAGE_BASE[7:3]) begin
              page_d = PAGE_W'(rx_byte[2:0]);
            end else if (mode_q == ModePage && rx_byte[7:5] == 3'b000) begin
              if (rx_byte[4]) begin
                col_d = (col_q & COL_W'(8'h0F)) | COL_W'({rx_byte[3:0], 4'h0});
              end else begin
                col_d = (col_q & ~COL_W'(8'h0F)) | COL_W'(rx_byte[3:0]);
              end
            end
          end
          StArg1: begin
            state_d = StIdle;
            case (cmd_q)
              SET_MEM_MODE: begin
                if (rx_byte[1:0] == 2'b00) begin
                  mode_d = ModeHoriz;
                end else if (rx_byte[1:0] == 2'b10) begin
                  mode_d = ModePage;
                end
              end
              SET_CONTRAST: contrast_d = rx_byte;
              SET_COL_ADDR: begin
                col_start_d = rx_byte[COL_W-1:0];
                state_d     = StArg2;
              end
              SET_PAGE_ADDR: begin
                page_start_d = rx_byte[PAGE_W-1:0];
                state_d      = StArg2;
              end
              default: ;
            endcase
          end
          StArg2: begin
            state_d = StIdle;
            if (cmd_q == SET_COL_ADDR) begin
              col_end_d = rx_byte[COL_W-1:0];
              col_d     = col_start_q;
            end else begin
              page_end_d = rx_byte[PAGE_W-1:0];
              page_d     = page_start_q;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  assign fb_addr_o  = addr_q;
  assign fb_dat_o   = dat_q;
  assign fb_wr_o    = wr_q;
  assign cmd_o      = cmd_q;
  assign cmd_stb_o  = stb_q;
  assign disp_on_o  = disp_on_q;
  assign contrast_o = contrast_q;
  assign frame_o    = frame_q;

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Self-checking bench for ssd1306_spi_rx: hand tables, corner sequences and a random stream.
module tb_ssd1306_spi_rx;

  localparam int S     = 2;
  localparam int COLS  = 128;
  localparam int PAGES = 8;
  localparam int AW    = 10;
  localparam int HALF  = 2;

  logic          clk = 1'b0;
  logic          rst, sck, mosi, ss, dc;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_dat, cmd, contrast;
  logic          fb_wr, cmd_stb, disp_on, frame;

  always #5 clk = ~clk;

  ssd1306_spi_rx #(
    .SYNC_STAGES  (S),
    .COLS         (COLS),
    .PAGES        (PAGES),
    .FB_ADDR_WIDTH(AW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .spi_sck_i (sck),
    .spi_mosi_i(mosi),
    .spi_ss_i  (ss),
    .spi_dc_i  (dc),
    .fb_addr_o (fb_addr),
    .fb_dat_o  (fb_dat),
    .fb_wr_o   (fb_wr),
    .cmd_o     (cmd),
    .cmd_stb_o (cmd_stb),
    .disp_on_o (disp_on),
    .contrast_o(contrast),
    .frame_o   (frame)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Observed and predicted transaction streams.
  int got_addr[$], got_dat[$], got_frame[$], got_cmd[$];
  int exp_addr[$], exp_dat[$], exp_frame[$], exp_cmd[$];
  logic prev_wr = 1'b0;
  int   bad_pulse = 0;

  always @(negedge clk) begin
    if (fb_wr) begin
      got_addr.push_back(int'(fb_addr));
      got_dat.push_back(int'(fb_dat));
      got_frame.push_back(int'(frame));
    end
    if (cmd_stb) got_cmd.push_back(int'(cmd));
    if ((fb_wr && prev_wr) || (frame && !fb_wr)) bad_pulse <= bad_pulse + 1;
    prev_wr <= fb_wr;
  end

  // Reference model of the display controller, byte by byte.
  int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_disp, m_contrast, m_op, m_args;

  task automatic m_reset();
    m_mode = 1; m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
    m_disp = 0; m_contrast = 'h7F; m_op = 0; m_args = 0;
  endtask

  task automatic m_byte(input bit isd, input int b);
    int f;
    if (isd) begin
      m_args = 0;
      exp_addr.push_back(m_page * COLS + m_col);
      exp_dat.push_back(b);
      f = 0;
      if (m_col == m_ce) begin
        m_col = m_cs;
        if (m_mode == 0) begin
          if (m_page == m_pe) begin m_page = m_ps; f = 1; end
          else m_page = (m_page + 1) % PAGES;
        end
      end else m_col = (m_col + 1) % COLS;
      exp_frame.push_back(f);
    end else if (m_args > 0) begin
      case (m_op)
        'h20: if ((b & 3) == 0) m_mode = 0; else if ((b & 3) == 2) m_mode = 1;
        'h81: m_contrast = b;
        'h21: if (m_args == 2) m_cs = b % COLS; else begin m_ce = b % COLS; m_col = m_cs; end
        'h22: if (m_args == 2) m_ps = b % PAGES; else begin m_pe = b % PAGES; m_page = m_ps; end
        default: ;
      endcase
      m_args--;
    end else begin
      m_op = b;
      exp_cmd.push_back(b);
      if (b == 'h21 || b == 'h22) m_args = 2;
      else if (b inside {'h20, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB}) m_args = 1;
      else if (b == 'hAE) m_disp = 0;
      else if (b == 'hAF) m_disp = 1;
      else if (b >= 'hB0 && b <= 'hB7) m_page = (b - 'hB0) % PAGES;
      else if (b < 'h10 && m_mode == 1) m_col = ((m_col & ~15) | b) % COLS;
      else if (b < 'h20 && m_mode == 1) m_col = ((m_col & 15) | ((b & 15) << 4)) % COLS;
    end
  endtask

  task automatic clear_queues();
    got_addr.delete(); got_dat.delete(); got_frame.delete(); got_cmd.delete();
    exp_addr.delete(); exp_dat.delete(); exp_frame.delete(); exp_cmd.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0; dc = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    m_reset();
    clear_queues();
  endtask

  task automatic settle();
    repeat (S + 4) @(negedge clk);
  endtask

  // Shifts one byte MSB first; optionally times the strobe of the last edge.
  task automatic send_byte(input bit isd, input logic [7:0] b, input bit lat);
    @(negedge clk);
    ss = 1'b0; dc = isd;
    repeat (HALF) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      if (lat && i == 0) begin
        repeat (S + 1) @(negedge clk);
        check("latency_early", int'(fb_wr | cmd_stb), 0);
        @(negedge clk);
        check("latency_strobe", int'(isd ? fb_wr : cmd_stb), 1);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sck = 1'b0;
    end
    m_byte(isd, int'(b));
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    @(negedge clk);
    ss = 1'b0; dc = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic compare_streams(input string name);
    int n;
    check($sformatf("%s_wr_count", name), got_addr.size(), exp_addr.size());
    check($sformatf("%s_cmd_count", name), got_cmd.size(), exp_cmd.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr[%0d]", name, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_dat[%0d]", name, i), got_dat[i], exp_dat[i]);
      check($sformatf("%s_frame[%0d]", name, i), got_frame[i], exp_frame[i]);
    end
    n = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_cmd[%0d]", name, i), got_cmd[i], exp_cmd[i]);
    clear_queues();
  endtask

  typedef struct {
    bit         isd;
    logic [7:0] val;
    logic [7:0] e_cmd;
    bit         e_disp;
    logic [7:0] e_contrast;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int frames, r, nb;
    logic [7:0] v;

    tbl[0] = '{1'b0, 8'hAF, 8'hAF, 1'b1, 8'h7F};
    tbl[1] = '{1'b0, 8'h81, 8'h81, 1'b1, 8'h7F};
    tbl[2] = '{1'b0, 8'h33, 8'h81, 1'b1, 8'h33};
    tbl[3] = '{1'b0, 8'hAE, 8'hAE, 1'b0, 8'h33};
    tbl[4] = '{1'b0, 8'hA8, 8'hA8, 1'b0, 8'h33};
    tbl[5] = '{1'b0, 8'h81, 8'hA8, 1'b0, 8'h33};
    tbl[6] = '{1'b0, 8'h81, 8'h81, 1'b0, 8'h33};
    tbl[7] = '{1'b0, 8'hC4, 8'h81, 1'b0, 8'hC4};
    tbl[8] = '{1'b0, 8'hE3, 8'hE3, 1'b0, 8'hC4};
    tbl[9] = '{1'b0, 8'hAF, 8'hAF, 1'b1, 8'hC4};

    rst = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0; dc = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_dat", int'(fb_dat), 0);
    check("rst_fb_wr", int'(fb_wr), 0);
    check("rst_cmd_stb", int'(cmd_stb), 0);
    check("rst_frame", int'(frame), 0);
    check("rst_cmd", int'(cmd), 0);
    check("rst_disp_on", int'(disp_on), 0);
    check("rst_contrast", int'(contrast), 'h7F);

    for (int i = 0; i < 10; i++) begin
      send_byte(tbl[i].isd, tbl[i].val, i == 0);
      settle();
      check($sformatf("tbl%0d_cmd", i), int'(cmd), int'(tbl[i].e_cmd));
      check($sformatf("tbl%0d_disp", i), int'(disp_on), int'(tbl[i].e_disp));
      check($sformatf("tbl%0d_contrast", i), int'(contrast), int'(tbl[i].e_contrast));
    end
    compare_streams("tbl");

    // Full horizontal window sweep.
    do_reset();
    send_byte(0, 8'h20, 0); send_byte(0, 8'h00, 0);
    send_byte(0, 8'h21, 0); send_byte(0, 8'h00, 0); send_byte(0, 8'h7F, 0);
    send_byte(0, 8'h22, 0); send_byte(0, 8'h00, 0); send_byte(0, 8'h07, 0);
    for (int i = 0; i < 1024; i++) send_byte(1, 8'($urandom), 0);
    settle();
    frames = 0;
    foreach (got_frame[i]) frames += got_frame[i];
    check("sweep_frame_count", frames, 1);
    check("sweep_writes", got_addr.size(), 1024);
    if (got_addr.size() == 1024) begin
      check("sweep_first_addr", got_addr[0], 0);
      check("sweep_last_addr", got_addr[1023], 1023);
      check("sweep_last_frame", got_frame[1023], 1);
    end
    compare_streams("sweep");

    // Page mode addressing.
    do_reset();
    send_byte(0, 8'hB3, 0); send_byte(0, 8'h05, 0); send_byte(0, 8'h12, 0);
    for (int i = 0; i < 3; i++) send_byte(1, 8'($urandom), 0);
    settle();
    check("page_writes", got_addr.size(), 3);
    if (got_addr.size() == 3) begin
      check("page_addr0", got_addr[0], 'h1A5);
      check("page_addr1", got_addr[1], 'h1A6);
      check("page_addr2", got_addr[2], 'h1A7);
    end
    compare_streams("page");

    // Data aborts a pending contrast argument.
    send_byte(0, 8'h81, 0);
    send_byte(1, 8'h55, 0);
    settle();
    check("abort_contrast", int'(contrast), 'h7F);
    check("abort_wr_count", got_addr.size(), 1);
    if (got_addr.size() == 1) begin
      check("abort_dat", got_dat[0], 'h55);
      check("abort_addr", got_addr[0], 'h1A8);
    end
    compare_streams("abort");

    // Chip select released mid-byte.
    send_bits(8'hFF, 5);
    ss = 1'b1;
    repeat (S + 4) @(negedge clk);
    send_byte(1, 8'hA5, 1);
    settle();
    check("ss_wr_count", got_dat.size(), 1);
    if (got_dat.size() == 1) check("ss_dat", got_dat[0], 'hA5);
    compare_streams("ss");

    // Reset between a window opcode and its arguments, and mid-byte.
    do_reset();
    send_byte(0, 8'h21, 0);
    settle();
    compare_streams("pre_rst");
    send_bits(8'h40, 3);
    do_reset();
    send_byte(1, 8'h3C, 0);
    send_byte(0, 8'h0F, 0); send_byte(0, 8'h17, 0);
    send_byte(1, 8'h11, 0); send_byte(1, 8'h22, 0);
    settle();
    check("rstmid_writes", got_addr.size(), 3);
    if (got_addr.size() == 3) begin
      check("rstmid_addr0", got_addr[0], 0);
      check("rstmid_addr1", got_addr[1], 127);
      check("rstmid_addr2", got_addr[2], 0);
    end
    compare_streams("rstmid");

    // Random command/data stream against the model.
    do_reset();
    for (int n = 0; n < 220; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: begin
          nb = $urandom_range(1, 6);
          for (int k = 0; k < nb; k++) send_byte(1, 8'($urandom), 0);
        end
        4: begin send_byte(0, 8'h20, 0); send_byte(0, 8'($urandom_range(0, 3)), 0); end
        5: begin
          send_byte(0, ($urandom_range(0, 1) != 0) ? 8'h21 : 8'h22, 0);
          send_byte(0, 8'($urandom), 0); send_byte(0, 8'($urandom), 0);
        end
        6: begin send_byte(0, 8'h81, 0); send_byte(0, 8'($urandom), 0); end
        7: begin
          v = 8'($urandom_range(0, 3));
          case (v)
            8'd0: send_byte(0, 8'hAE, 0);
            8'd1: send_byte(0, 8'hAF, 0);
            8'd2: send_byte(0, 8'(8'hB0 + $urandom_range(0, 7)), 0);
            default: send_byte(0, 8'($urandom_range(0, 31)), 0);
          endcase
        end
        8: send_byte(0, 8'($urandom), 0);
        default: begin
          send_byte(0, ($urandom_range(0, 1) != 0) ? 8'h21 : 8'h81, 0);
          send_byte(1, 8'($urandom), 0);
        end
      endcase
    end
    settle();
    check("rand_cmd_o", int'(cmd), m_op);
    check("rand_disp_on", int'(disp_on), m_disp);
    check("rand_contrast", int'(contrast), m_contrast);
    compare_streams("rand");

    check("pulse_shape", bad_pulse, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
